// File: rtl/ctrl_seq.sv
// Multicycle sequencer: fetches into IR, steps FETCH/DECODE/EXEC/MEM/WB,
// drives PC/regfile/dmem strobes, and traps on halt or memory timeout.
module ctrl_seq #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_rdy,
  input  logic [15:0]      instr,
  output logic [4:0]       ir_opcode,
  output logic [1:0]       ir_op_ext,
  input  logic             dec_halt,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_sel_wb,
  input  logic             dec_redirect,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_rdy,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             redir_q, redir_d;
  logic             rfw_q, rfw_d;

  logic [WW-1:0]    wait_inc;
  logic             tmo_hit;
  logic             unused_ir;

  assign unused_ir = ^ir_q[10:2];

  assign wait_inc = wait_q + 1'b1;
  assign tmo_hit  = (MEM_TIMEOUT != 0) && (wait_inc == TMO);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    redir_d = redir_q;
    rfw_d   = rfw_q;
    unique case (state_q)
      S_FETCH: begin
        // run low just pauses the fetch; the wait count is held
        if (run) begin
          if (imem_rdy) begin
            ir_d    = instr;
            wait_d  = '0;
            state_d = S_DECODE;
          end else if (tmo_hit) begin
            wait_d  = '0;
            state_d = S_ERR;
          end else begin
            wait_d  = wait_inc;
          end
        end
      end
      S_DECODE: begin
        state_d = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        rd_d    = dec_sel_wb;
        wr_d    = dec_mem_write;
        redir_d = dec_redirect;
        rfw_d   = dec_reg_write;
        state_d = (dec_sel_wb | dec_mem_write) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_rdy) begin
          wait_d  = '0;
          state_d = S_WB;
        end else if (tmo_hit) begin
          wait_d  = '0;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_inc;
        end
      end
      S_WB: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      redir_q <= 1'b0;
      rfw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      redir_q <= redir_d;
      rfw_q   <= rfw_d;
    end
  end

  // imem_req is the only output fed by an input, so gate it with rst too
  assign imem_req    = ~rst & run & (state_q == S_FETCH);
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = (state_q == S_MEM) & wr_q;
  assign pc_we       = (state_q == S_WB);
  assign pc_redirect = (state_q == S_WB) & redir_q;
  assign rf_we       = (state_q == S_WB) & rfw_q & ~wr_q;
  assign halted      = (state_q == S_HALT);
  assign err         = (state_q == S_ERR);
  assign state       = state_q;
  assign instret     = cnt_q;
  assign ir_opcode   = ir_q[15:11];
  assign ir_op_ext   = ir_q[1:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq: a toy decoder derives flags from the opcode,
// and per-instruction latency/strobe counts are predicted from the flags.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       imem_req;
  logic       imem_rdy = 1'b0;
  logic [15:0] instr = '0;
  logic [4:0] ir_opcode;
  logic [1:0] ir_op_ext;
  logic       dec_halt, dec_reg_write, dec_mem_write, dec_sel_wb, dec_redirect;
  logic       dmem_req, dmem_we;
  logic       dmem_rdy = 1'b0;
  logic       rf_we, pc_we, pc_redirect, halted, err;
  logic [2:0] state;
  logic [3:0] instret;

  int n_chk = 0;
  int n_fail = 0;
  int model_ret = 0;

  always #5 clk = ~clk;

  // toy decoder: opcode bit0 load, bit1 store, bit2 reg write, bit3 branch
  assign dec_halt      = (ir_opcode == 5'h1f);
  assign dec_sel_wb    = ir_opcode[0];
  assign dec_mem_write = ir_opcode[1];
  assign dec_reg_write = ir_opcode[2];
  assign dec_redirect  = ir_opcode[3] & ir_op_ext[0];

  ctrl_seq #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_rdy(imem_rdy), .instr(instr),
    .ir_opcode(ir_opcode), .ir_op_ext(ir_op_ext),
    .dec_halt(dec_halt), .dec_reg_write(dec_reg_write),
    .dec_mem_write(dec_mem_write), .dec_sel_wb(dec_sel_wb),
    .dec_redirect(dec_redirect),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rdy(dmem_rdy),
    .rf_we(rf_we), .pc_we(pc_we), .pc_redirect(pc_redirect),
    .halted(halted), .err(err), .state(state), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_ret = 0;
  endtask

  // one instruction: rz run-low cycles, fd fetch waits, md dmem waits
  task automatic do_instr(input logic [15:0] ins, input int rz,
                          input int fd, input int md);
    logic [4:0] op;
    bit ld, st, rw, rd, memop, done, dec_ok;
    int exp_lat, cyc, fcnt, mcnt, rzc;
    int n_pc, n_rf, n_dr, n_dw, n_rx, n_ir;
    op = ins[15:11];
    ld = op[0]; st = op[1]; rw = op[2]; rd = op[3] & ins[0];
    memop = ld | st;
    exp_lat = rz + fd + 4 + (memop ? md + 1 : 0);
    cyc = 0; fcnt = 0; mcnt = 0; rzc = 0; done = 0; dec_ok = 0;
    n_pc = 0; n_rf = 0; n_dr = 0; n_dw = 0; n_rx = 0; n_ir = 0;
    instr = ins;
    while (!done && cyc < 60) begin
      @(negedge clk);
      imem_rdy = 1'($urandom);
      dmem_rdy = 1'($urandom);
      if (state == 3'd0) begin
        if (rzc < rz) begin
          run = 1'b0;
          rzc++;
        end else begin
          run = 1'b1;
          imem_rdy = (fcnt == fd);
          fcnt++;
        end
      end else if (state == 3'd3) begin
        dmem_rdy = (mcnt == md);
        mcnt++;
      end
      #1;
      cyc++;
      n_pc += int'(pc_we);
      n_rf += int'(rf_we);
      n_dr += int'(dmem_req);
      n_dw += int'(dmem_we);
      n_rx += int'(pc_redirect);
      n_ir += int'(imem_req);
      if (state == 3'd1)
        dec_ok = (ir_opcode == op) && (ir_op_ext == ins[1:0]);
      if (state == 3'd4) done = 1;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("imem_req_cycles", 32'(n_ir), 32'(fd + 1));
    chk("pc_we_cycles", 32'(n_pc), 32'd1);
    chk("rf_we_cycles", 32'(n_rf), 32'(rw & ~st));
    chk("dmem_req_cycles", 32'(n_dr), 32'(memop ? md + 1 : 0));
    chk("dmem_we_cycles", 32'(n_dw), 32'(st ? md + 1 : 0));
    chk("redirect_cycles", 32'(n_rx), 32'(rd));
    chk("ir_fields", 32'(dec_ok), 32'd1);
    model_ret++;
    @(posedge clk);
    #1;
    chk("back_to_fetch", 32'(state), 32'd0);
    chk("instret", 32'(instret), 32'(model_ret % 16));
  endtask

  // hold rdy low in FETCH or MEM; expect ERR after 4 wait cycles
  task automatic tmo_run(input bit in_mem);
    int cyc, n_tgt, n_pc;
    logic [2:0] tgt;
    tgt = in_mem ? 3'd3 : 3'd0;
    cyc = 0; n_tgt = 0; n_pc = 0;
    instr = 16'h0800;
    while (state != 3'd6 && cyc < 30) begin
      @(negedge clk);
      run = 1'b1;
      imem_rdy = in_mem;
      dmem_rdy = 1'b0;
      #1;
      cyc++;
      n_pc += int'(pc_we);
      if (state == tgt) n_tgt++;
    end
    chk(in_mem ? "tmo_mem_waits" : "tmo_fetch_waits", 32'(n_tgt), 32'd4);
    chk("tmo_state", 32'(state), 32'd6);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_no_pc_we", 32'(n_pc), 32'd0);
    chk("tmo_req_off", 32'(imem_req | dmem_req), 32'd0);
  endtask

  initial begin
    int n_bad;
    logic [15:0] ins;
    @(negedge clk);
    run = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_strobes", 32'({pc_we, rf_we, dmem_req, halted, err}), 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_instr(16'h2000, 0, 0, 0);
    do_instr(16'h3000, 0, 0, 3);
    do_instr(16'h4001, 0, 0, 0);
    do_instr(16'h1800, 0, 1, 2);
    do_instr(16'h2800, 0, 3, 0);

    do_reset();
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      ins[15:11] = 5'($urandom_range(0, 30));
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 3));
      if (i == 16) chk("wrap17", 32'(instret), 32'd1);
    end

    instr = 16'hf800;
    n_bad = 0;
    while (state != 3'd5 && n_bad < 10) begin
      @(negedge clk);
      run = 1'b1;
      imem_rdy = 1'b1;
      #1;
      n_bad++;
    end
    chk("halt_state", 32'(state), 32'd5);
    chk("halted", 32'(halted), 32'd1);
    n_bad = 0;
    repeat (100) begin
      @(negedge clk);
      imem_rdy = 1'($urandom);
      dmem_rdy = 1'($urandom);
      #1;
      n_bad += int'(imem_req | pc_we | rf_we | dmem_req);
    end
    chk("halt_quiet", 32'(n_bad), 32'd0);
    chk("halt_instret", 32'(instret), 32'(model_ret % 16));
    chk("halt_err", 32'(err), 32'd0);

    do_reset();
    tmo_run(1'b0);
    do_reset();
    tmo_run(1'b1);

    do_reset();
    instr = 16'h0800;
    n_bad = 0;
    while (state != 3'd3 && n_bad < 10) begin
      @(negedge clk);
      run = 1'b1;
      imem_rdy = 1'b1;
      dmem_rdy = 1'b0;
      #1;
      n_bad++;
    end
    chk("mid_mem_req", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_drop_dmem", 32'(dmem_req), 32'd0);
    chk("rst_drop_imem", 32'(imem_req), 32'd0);
    chk("rst_async_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_instret", 32'(instret), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
